// File: rtl/seq_add_sub.sv
// Sequential adder/subtractor: processes DIGIT bits per clock, LSB slice first,
// and publishes result, carry and two's-complement overflow once per operation.
module seq_add_sub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             sub_q;
   logic             cy;

   logic [DIGIT-1:0] a_dig;
   logic [DIGIT-1:0] b_dig;
   logic [DIGIT:0]   dig_sum;
   logic             c_msb;
   logic [WIDTH-1:0] res_nxt;

   function automatic logic [DIGIT:0] slice_add(input logic [DIGIT-1:0] x,
                                                input logic [DIGIT-1:0] y,
                                                input logic             ci);
      return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
   endfunction

   assign a_dig   = a_sh[DIGIT-1:0];
   assign b_dig   = b_sh[DIGIT-1:0] ^ {DIGIT{sub_q}};
   assign dig_sum = slice_add(a_dig, b_dig, cy);
   // Carry into the slice MSB recovered from its sum bit; on the last slice this is bit WIDTH-1.
   assign c_msb   = dig_sum[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
   assign res_nxt = WIDTH'({dig_sum[DIGIT-1:0], res_sh} >> DIGIT);

   assign busy = (state == RUN);
   assign done = (state == FIN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         sub_q    <= 1'b0;
         cy       <= 1'b0;
         result   <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE, FIN: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  sub_q <= sub;
                  cy    <= sub;
                  cnt   <= '0;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> DIGIT;
               b_sh   <= b_sh >> DIGIT;
               res_sh <= res_nxt;
               cy     <= dig_sum[DIGIT];
               cnt    <= cnt + CW'(1);
               if (cnt == LAST) begin
                  state    <= FIN;
                  result   <= res_nxt;
                  carry    <= dig_sum[DIGIT];
                  overflow <= c_msb ^ dig_sum[DIGIT];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_add_sub.sv
// Bench for seq_add_sub: WIDTH=8 with DIGIT 1/2/4/8 plus WIDTH=16/DIGIT=4,
// checked against constant vectors and an integer-arithmetic reference model.
module tb_seq_add_sub;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sub;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [15:0] a16;
   logic [15:0] b16;

   logic        busy8 [4];
   logic        done8 [4];
   logic [7:0]  res8  [4];
   logic        cy8   [4];
   logic        ov8   [4];

   logic        busy16;
   logic        done16;
   logic [15:0] res16;
   logic        cy16;
   logic        ov16;

   int ntests = 0;
   int nfail  = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       s;
      logic [7:0] r;
      logic       c;
      logic       v;
   } vec_t;

   vec_t tbl [8];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g8
      seq_add_sub #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
         .clk      (clk),
         .rst      (rst),
         .start    (start),
         .sub      (sub),
         .a        (a),
         .b        (b),
         .busy     (busy8[g]),
         .done     (done8[g]),
         .result   (res8[g]),
         .carry    (cy8[g]),
         .overflow (ov8[g])
      );
   end

   seq_add_sub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sub      (sub),
      .a        (a16),
      .b        (b16),
      .busy     (busy16),
      .done     (done16),
      .result   (res16),
      .carry    (cy16),
      .overflow (ov16)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed interpretations.
   task automatic model(input int w, input longint unsigned x, input longint unsigned y,
                        input bit s, output longint unsigned r, output bit c, output bit v);
      longint unsigned m;
      longint hi, sx, sy, sr;
      m  = (64'd1 << w) - 64'd1;
      hi = longint'(64'd1 << (w - 1));
      r  = (s ? x - y : x + y) & m;
      c  = s ? (x >= y) : ((x + y) > m);
      sx = (x >= hi) ? longint'(x) - 2 * hi : longint'(x);
      sy = (y >= hi) ? longint'(y) - 2 * hi : longint'(y);
      sr = s ? sx - sy : sx + sy;
      v  = (sr >= hi) || (sr < -hi);
   endtask

   // One operation on all instances; checks latency, busy length and outputs.
   task automatic run_all(input logic [7:0] xa, input logic [7:0] xb,
                          input logic [15:0] ya, input logic [15:0] yb, input logic s);
      int lat [5];
      int nb;
      longint unsigned r;
      bit c, v;
      a = xa; b = xb; a16 = ya; b16 = yb; sub = s; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) lat[i] = -1;
      nb = busy8[0] ? 1 : 0;
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (busy8[0]) nb++;
         for (int g = 0; g < 4; g++)
            if (done8[g] && lat[g] < 0) lat[g] = e;
         if (done16 && lat[4] < 0) lat[4] = e;
      end
      chk("busy_cycles_d1", 64'(nb), 64'd8);
      model(8, xa, xb, s, r, c, v);
      for (int g = 0; g < 4; g++) begin
         chk($sformatf("lat_d%0d", 1 << g), 64'(lat[g]), 64'(8 >> g));
         chk($sformatf("result_d%0d", 1 << g), 64'(res8[g]), r);
         chk($sformatf("carry_d%0d", 1 << g), 64'(cy8[g]), 64'(c));
         chk($sformatf("ovf_d%0d", 1 << g), 64'(ov8[g]), 64'(v));
      end
      model(16, ya, yb, s, r, c, v);
      chk("lat_w16", 64'(lat[4]), 64'd4);
      chk("result_w16", 64'(res16), r);
      chk("carry_w16", 64'(cy16), 64'(c));
      chk("ovf_w16", 64'(ov16), 64'(v));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      int e;
      int dn;

      tbl[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[2] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
      tbl[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
      tbl[4] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl[6] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};
      tbl[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};

      rst = 1'b1; start = 1'b0; sub = 1'b0;
      a = '0; b = '0; a16 = '0; b16 = '0;
      #12;
      chk("rst_busy", 64'(busy8[0]), 64'd0);
      chk("rst_done", 64'(done8[0]), 64'd0);
      chk("rst_result", 64'(res8[0]), 64'd0);
      chk("rst_carry", 64'(cy8[0]), 64'd0);
      chk("rst_ovf", 64'(ov8[0]), 64'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) begin
         run_all(tbl[i].a, tbl[i].b, 16'($urandom), 16'($urandom), tbl[i].s);
         chk($sformatf("tbl%0d_result", i), 64'(res8[0]), 64'(tbl[i].r));
         chk($sformatf("tbl%0d_carry", i), 64'(cy8[0]), 64'(tbl[i].c));
         chk($sformatf("tbl%0d_ovf", i), 64'(ov8[0]), 64'(tbl[i].v));
      end

      for (int i = 0; i < 30; i++)
         run_all(8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));

      // START during RUN is ignored and old outputs hold through the run.
      run_all(8'h12, 8'h34, 16'h0001, 16'h0002, 1'b0);
      a = 8'h30; b = 8'h05; sub = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("hold_during_run", 64'(res8[0]), 64'h46);
      a = 8'h11; b = 8'h22; sub = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      e = 3;
      while (!done8[0] && e < 30) begin
         tick();
         e++;
      end
      chk("ignore_lat", 64'(e), 64'd8);
      chk("ignore_result", 64'(res8[0]), 64'h35);
      chk("ignore_carry", 64'(cy8[0]), 64'd0);
      tick();
      tick();

      // Back-to-back with START held high through FIN.
      a = 8'h40; b = 8'h40; sub = 1'b0; start = 1'b1;
      tick();
      a = 8'hC8; b = 8'h05; sub = 1'b1;
      e = 0;
      while (!done8[0] && e < 30) begin
         tick();
         e++;
      end
      chk("b2b_lat", 64'(e), 64'd8);
      chk("b2b_result1", 64'(res8[0]), 64'h80);
      chk("b2b_ovf1", 64'(ov8[0]), 64'd1);
      tick();
      start = 1'b0;
      e = 1;
      while (!done8[0] && e < 30) begin
         tick();
         e++;
      end
      chk("b2b_interval", 64'(e), 64'd9);
      chk("b2b_result2", 64'(res8[0]), 64'hC3);
      chk("b2b_carry2", 64'(cy8[0]), 64'd1);
      tick();
      tick();

      // Asynchronous reset part-way through an operation.
      a = 8'h0F; b = 8'h01; sub = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 64'(busy8[0]), 64'd0);
      chk("arst_done", 64'(done8[0]), 64'd0);
      chk("arst_result", 64'(res8[0]), 64'd0);
      chk("arst_carry", 64'(cy8[0]), 64'd0);
      chk("arst_ovf", 64'(ov8[0]), 64'd0);
      a = 8'h55; b = 8'h11; start = 1'b1;
      tick();
      chk("rst_ignores_start", 64'(busy8[0]), 64'd0);
      #2 rst = 1'b0;
      start = 1'b0;
      dn = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done8[0] || busy8[0]) dn++;
      end
      chk("no_done_after_abort", 64'(dn), 64'd0);
      run_all(8'h7F, 8'h01, 16'h7FFF, 16'h0001, 1'b0);
      chk("post_rst_result", 64'(res8[0]), 64'h80);
      chk("post_rst_ovf16", 64'(ov16), 64'd1);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
